crc32_stream_append: RTL and testbench

- Byte-wide streaming CRC32 generator.
- Accepts a framed byte stream, forwards each byte unchanged, and appends the 4-byte CRC32 after the last payload byte.
- Sits directly downstream of the packet source and upstream of the link/serialiser. Its appended CRC is what the crc32_pkg reference model checks.
- Polynomial, init, xorout and reflection settings are parameters. One instance covers ISO-HDLC, BZIP2, iSCSI, MPEG-2 and similar variants.

---
 rtl/crc32_stream_append.sv | 154 +++++++++++++++
 tb/tb_crc32_stream_append.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_stream_append.sv
// Byte-stream CRC32 appender: forwards payload bytes and appends the 4-byte CRC after s_last (optional frame_cnt via CRC32_STREAM_APPEND_FRAME_CNT_EN).
// Latency: 1 cycle input-to-output; every frame costs N+4 output cycles at full rate.
// Backpressure: single output register; s_ready follows slot free and is low while the CRC bytes are emitted.
module crc32_stream_append #(
  parameter logic [31:0] POLY          = 32'h04C11DB7,
  parameter logic [31:0] INIT          = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT        = 32'hFFFFFFFF,
  parameter bit          REFIN         = 1'b1,
  parameter bit          REFOUT        = 1'b1,
  parameter bit          CRC_LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic [31:0] crc_out,
  output logic        crc_done
`ifdef CRC32_STREAM_APPEND_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  typedef enum logic {ST_PASS, ST_APPEND} state_t;

  state_t      state_q, state_nxt;
  logic [31:0] crc_q, crc_nxt;
  logic [1:0]  idx_q, idx_nxt;
  logic        m_valid_nxt;
  logic [7:0]  m_data_nxt;
  logic        m_last_nxt;
  logic [31:0] crc_out_nxt;
  logic        crc_done_nxt;

  logic        slot_free;
  logic        in_xfer;
  logic [7:0]  crc_in_byte;
  logic [31:0] crc_step_res;
  logic [31:0] crc_fin;
  logic [7:0]  crc_byte;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[31-i];
    return r;
  endfunction

  // Eight MSB-first shifts of the normal-form polynomial.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {b, 24'h000000};
    for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  assign slot_free    = !m_valid || m_ready;
  assign s_ready      = (state_q == ST_PASS) && slot_free;
  assign in_xfer      = s_valid && s_ready;
  assign crc_in_byte  = REFIN ? bitrev8(s_data) : s_data;
  assign crc_step_res = crc_step(crc_q, crc_in_byte);
  assign crc_fin      = (REFOUT ? bitrev32(crc_step_res) : crc_step_res) ^ XOROUT;

  // ~idx maps 0..3 onto 3..0 for MSB-first emission.
  assign crc_byte = CRC_LSB_FIRST ? crc_out[{idx_q, 3'b000} +: 8]
                                  : crc_out[{~idx_q, 3'b000} +: 8];

  always_comb begin
    state_nxt    = state_q;
    crc_nxt      = crc_q;
    idx_nxt      = idx_q;
    m_valid_nxt  = m_valid;
    m_data_nxt   = m_data;
    m_last_nxt   = m_last;
    crc_out_nxt  = crc_out;
    crc_done_nxt = 1'b0;
    case (state_q)
      ST_PASS: begin
        if (in_xfer) begin
          m_valid_nxt = 1'b1;
          m_data_nxt  = s_data;
          m_last_nxt  = 1'b0;
          crc_nxt     = crc_step_res;
          if (s_last) begin
            crc_out_nxt  = crc_fin;
            crc_done_nxt = 1'b1;
            idx_nxt      = 2'd0;
            state_nxt    = ST_APPEND;
          end
        end else if (slot_free) begin
          m_valid_nxt = 1'b0;
        end
      end
      ST_APPEND: begin
        if (slot_free) begin
          m_valid_nxt = 1'b1;
          m_data_nxt  = crc_byte;
          m_last_nxt  = (idx_q == 2'd3);
          idx_nxt     = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            crc_nxt   = INIT;
            state_nxt = ST_PASS;
          end
        end
      end
      default: state_nxt = ST_PASS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_PASS;
      crc_q    <= INIT;
      idx_q    <= 2'd0;
      m_valid  <= 1'b0;
      m_data   <= 8'h00;
      m_last   <= 1'b0;
      crc_out  <= 32'h0;
      crc_done <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      crc_q    <= crc_nxt;
      idx_q    <= idx_nxt;
      m_valid  <= m_valid_nxt;
      m_data   <= m_data_nxt;
      m_last   <= m_last_nxt;
      crc_out  <= crc_out_nxt;
      crc_done <= crc_done_nxt;
    end
  end

`ifdef CRC32_STREAM_APPEND_FRAME_CNT_EN
  // Counts frames as they leave, i.e. on the accepted last CRC byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 16'h0000;
    end else if (m_valid && m_ready && m_last) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crc32_stream_append.sv
// Bench: ISO-HDLC and BZIP2 instances fed the same stream, checked against a byte-level CRC model.
module tb_crc32_stream_append;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_ready;

  logic        a_s_ready, a_m_valid, a_m_last, a_crc_done;
  logic [7:0]  a_m_data;
  logic [31:0] a_crc_out;
  logic        b_s_ready, b_m_valid, b_m_last, b_crc_done;
  logic [7:0]  b_m_data;
  logic [31:0] b_crc_out;
`ifdef CRC32_STREAM_APPEND_FRAME_CNT_EN
  logic [15:0] a_frame_cnt, b_frame_cnt;
`endif

  always #5 clk = ~clk;

  crc32_stream_append dut_a (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data), .m_last(a_m_last),
    .crc_out(a_crc_out), .crc_done(a_crc_done)
`ifdef CRC32_STREAM_APPEND_FRAME_CNT_EN
    , .frame_cnt(a_frame_cnt)
`endif
  );

  crc32_stream_append #(
    .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOROUT(32'hFFFFFFFF),
    .REFIN(1'b0), .REFOUT(1'b0), .CRC_LSB_FIRST(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data), .m_last(b_m_last),
    .crc_out(b_crc_out), .crc_done(b_crc_done)
`ifdef CRC32_STREAM_APPEND_FRAME_CNT_EN
    , .frame_cnt(b_frame_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_pct  = 100;
  int done_cnt = 0;

  logic [8:0]  qa[$];
  logic [8:0]  qb[$];
  logic [31:0] ca[$];
  logic [31:0] cb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reflected (LSB-first) formulation of CRC-32/ISO-HDLC.
  function automatic logic [31:0] iso_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] bz_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {b, 24'h0};
    for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    return r;
  endfunction

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  // Scoreboard: expected bytes are queued on each accepted input, popped on each output transfer.
  initial begin
    logic [31:0] run_a, run_b, fa, fb;
    logic        pa_stall, pb_stall;
    logic [8:0]  pa, pb, e;
    run_a = 32'hFFFFFFFF; run_b = 32'hFFFFFFFF;
    pa_stall = 1'b0; pb_stall = 1'b0; pa = '0; pb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        qa.delete(); qb.delete(); ca.delete(); cb.delete();
        run_a = 32'hFFFFFFFF; run_b = 32'hFFFFFFFF;
        pa_stall = 1'b0; pb_stall = 1'b0;
        check("rst_a_out", {21'h0, a_m_valid, a_m_last, a_m_data, a_crc_done}, 32'h0);
        check("rst_a_crc", a_crc_out, 32'h0);
        check("rst_b_out", {21'h0, b_m_valid, b_m_last, b_m_data, b_crc_done}, 32'h0);
        check("rst_b_crc", b_crc_out, 32'h0);
      end else begin
        if (pa_stall) check("a_hold", {22'h0, a_m_valid, a_m_last, a_m_data}, {22'h0, 1'b1, pa});
        if (pb_stall) check("b_hold", {22'h0, b_m_valid, b_m_last, b_m_data}, {22'h0, 1'b1, pb});
        if (a_m_valid && m_ready) begin
          if (qa.size() == 0) check("a_extra_byte", {23'h0, a_m_last, a_m_data}, 32'hFFFFFFFF);
          else begin e = qa.pop_front(); check("a_out", {23'h0, a_m_last, a_m_data}, {23'h0, e}); end
        end
        if (b_m_valid && m_ready) begin
          if (qb.size() == 0) check("b_extra_byte", {23'h0, b_m_last, b_m_data}, 32'hFFFFFFFF);
          else begin e = qb.pop_front(); check("b_out", {23'h0, b_m_last, b_m_data}, {23'h0, e}); end
        end
        pa_stall = a_m_valid && !m_ready; pa = {a_m_last, a_m_data};
        pb_stall = b_m_valid && !m_ready; pb = {b_m_last, b_m_data};
        if (a_crc_done) begin
          done_cnt++;
          if (ca.size() == 0) check("a_spurious_done", a_crc_out, 32'hDEADBEEF);
          else check("a_crc_out", a_crc_out, ca.pop_front());
        end
        if (b_crc_done) begin
          if (cb.size() == 0) check("b_spurious_done", b_crc_out, 32'hDEADBEEF);
          else check("b_crc_out", b_crc_out, cb.pop_front());
        end
        check("b_s_ready", {31'h0, b_s_ready}, {31'h0, a_s_ready});
        if (s_valid && a_s_ready) begin
          qa.push_back({1'b0, s_data});
          qb.push_back({1'b0, s_data});
          run_a = iso_upd(run_a, s_data);
          run_b = bz_upd(run_b, s_data);
          if (s_last) begin
            fa = ~run_a;
            fb = ~run_b;
            for (int i = 0; i < 4; i++) begin
              qa.push_back({i == 3, fa[8*i +: 8]});
              qb.push_back({i == 3, fb[8*(3-i) +: 8]});
            end
            ca.push_back(fa);
            cb.push_back(fb);
            run_a = 32'hFFFFFFFF; run_b = 32'hFFFFFFFF;
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap_pct);
    int cyc;
    while ($urandom_range(99) < gap_pct) begin
      s_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1; s_data = b; s_last = last;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (a_s_ready) break;
      cyc++;
      if (cyc > 500) begin
        check("s_ready_timeout", {31'h0, a_s_ready}, 32'h1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input int gap_pct);
    for (int i = 0; i < bytes.size(); i++) send_byte(bytes[i], i == bytes.size() - 1, gap_pct);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((qa.size() != 0 || qb.size() != 0) && cyc < 1000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 1000) check("drain_timeout", qa.size() + qb.size(), 32'h0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", {31'h0, a_s_ready, b_s_ready} , 32'h3);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  f9[$];
    logic [7:0]  f1[$];
    logic [7:0]  fr[$];
    logic [31:0] c;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    for (int i = 0; i < 9; i++) f9.push_back(8'h31 + 8'(i));
    f1.push_back(8'h00);

    c = 32'hFFFFFFFF;
    foreach (f9[i]) c = iso_upd(c, f9[i]);
    check("model_iso_123456789", ~c, 32'hCBF43926);
    c = 32'hFFFFFFFF;
    foreach (f9[i]) c = bz_upd(c, f9[i]);
    check("model_bz_123456789", ~c, 32'hFC891918);
    c = iso_upd(32'hFFFFFFFF, 8'h00);
    check("model_iso_00", ~c, 32'hD202EF8D);

    repeat (2) @(negedge clk);
    do_reset();

    rdy_pct = 100;
    send_frame(f9, 0);
    drain();
    check("iso_crc_lit", a_crc_out, 32'hCBF43926);
    check("bz_crc_lit", b_crc_out, 32'hFC891918);
    check("done_cnt_1", done_cnt, 1);

    send_frame(f1, 0);
    drain();
    check("iso_single_lit", a_crc_out, 32'hD202EF8D);

    rdy_pct = 50;
    send_frame(f9, 30);
    send_frame(f9, 30);
    drain();
    check("b2b_iso_lit", a_crc_out, 32'hCBF43926);
    check("done_cnt_4", done_cnt, 4);

    for (int f = 0; f < 8; f++) begin
      fr.delete();
      for (int i = 0; i < int'($urandom_range(12, 1)); i++) fr.push_back(8'($urandom));
      rdy_pct = int'($urandom_range(100, 30));
      send_frame(fr, int'($urandom_range(40)));
    end
    drain();
    check("done_cnt_12", done_cnt, 12);

    rdy_pct = 100;
    for (int i = 0; i < 5; i++) send_byte(f9[i], 1'b0, 0);
    do_reset();
    send_frame(f9, 0);
    drain();
    check("after_rst_iso", a_crc_out, 32'hCBF43926);
    check("after_rst_bz", b_crc_out, 32'hFC891918);

`ifdef CRC32_STREAM_APPEND_FRAME_CNT_EN
    do_reset();
    rdy_pct = 60;
    for (int f = 0; f < 3; f++) send_frame(f1, 10);
    drain();
    check("frame_cnt_3", a_frame_cnt, 3);
    check("b_frame_cnt_3", b_frame_cnt, 3);
    force dut_a.frame_cnt = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut_a.frame_cnt;
    send_frame(f1, 0);
    drain();
    check("frame_cnt_wrap", a_frame_cnt, 0);
`endif

    check("queues_empty", qa.size() + qb.size() + ca.size() + cb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
